// File: rtl/delta_pkg.sv
// Shared definitions for the delta-modulation spike encoder: spike codes and
// default widths.
package delta_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_REFRACT_W = 4;

    // Bit 1 = ON, bit 0 = OFF; the two are never set together.
    typedef logic [1:0] spike_t;

    localparam spike_t SPIKE_NONE = 2'b00;
    localparam spike_t SPIKE_ON   = 2'b10;
    localparam spike_t SPIKE_OFF  = 2'b01;

endpackage

// File: rtl/delta_spike_encoder_if.sv
// Sample-in / spike-out handshake bundle. The master side is the environment;
// the slave side is the encoder.
interface delta_spike_encoder_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 2
);

    logic                   in_valid;
    logic                   in_ready;
    logic [NCH*WIDTH-1:0]   in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [NCH-1:0]         spike_on;
    logic [NCH-1:0]         spike_off;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, spike_on, spike_off
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, spike_on, spike_off
    );

endinterface

// File: rtl/delta_channel.sv
// One encoder channel: reference register, refractory counter and the
// signed delta comparison that produces the next spike code.
module delta_channel
    import delta_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int REFRACT_W = DEF_REFRACT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step,
    input  logic                 primed,
    input  logic [WIDTH-1:0]     data,
    input  logic [WIDTH-1:0]     threshold,
    input  logic [REFRACT_W-1:0] refract,
    input  logic                 off_en,
    output spike_t               spike
);

    logic [WIDTH-1:0]     ref_q;
    logic [REFRACT_W-1:0] refr_cnt;
    logic signed [WIDTH:0] diff;
    logic signed [WIDTH:0] thr;
    logic                 up;
    logic                 dn;

    // One extra bit keeps the difference exact, so 255 -> 0 is a fall, not a wrap.
    assign diff = $signed({1'b0, data}) - $signed({1'b0, ref_q});
    assign thr  = $signed({1'b0, threshold});
    assign up   = diff > thr;
    assign dn   = off_en && (diff < -thr);

    always_comb begin
        // NOTE: default first so every path assigns spike and no latch is inferred.
        spike = SPIKE_NONE;
        if (primed && refr_cnt == '0) begin
            if (up)      spike = SPIKE_ON;
            else if (dn) spike = SPIKE_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: non-blocking for all sequential state so every flop sees pre-edge values.
            ref_q    <= '0;
            refr_cnt <= '0;
        end else if (step) begin
            if (!primed) begin
                ref_q    <= data;
                refr_cnt <= '0;
            end else if (refr_cnt != '0) begin
                refr_cnt <= refr_cnt - 1'b1;
            end else if (up || dn) begin
                ref_q    <= data;
                refr_cnt <= refract;
            end
        end
    end

endmodule

// File: rtl/delta_spike_encoder.sv
// Multi-channel delta spike encoder top: per-channel compare units, priming
// flag and a one-entry valid/ready output register.
module delta_spike_encoder
    import delta_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NCH       = 2,
    parameter int REFRACT_W = DEF_REFRACT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [WIDTH-1:0]     threshold,
    input  logic [REFRACT_W-1:0] refract,
    input  logic                 off_en,
    delta_spike_encoder_if.slave bus
);

    logic           acc;
    logic           primed;
    logic           out_valid_q;
    logic [NCH-1:0] spike_on_q;
    logic [NCH-1:0] spike_off_q;
    spike_t         next_spike [NCH];

    assign bus.in_ready  = ena && (!out_valid_q || bus.out_ready);
    assign acc           = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.spike_on  = spike_on_q;
    assign bus.spike_off = spike_off_q;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        delta_channel #(
            .WIDTH     (WIDTH),
            .REFRACT_W (REFRACT_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .step      (acc),
            .primed    (primed),
            .data      (bus.in_data[c*WIDTH +: WIDTH]),
            .threshold (threshold),
            .refract   (refract),
            .off_en    (off_en),
            .spike     (next_spike[c])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            primed      <= 1'b0;
            out_valid_q <= 1'b0;
            spike_on_q  <= '0;
            spike_off_q <= '0;
        end else if (acc) begin
            primed      <= 1'b1;
            out_valid_q <= 1'b1;
            for (int c = 0; c < NCH; c++) begin
                spike_on_q[c]  <= (next_spike[c] == SPIKE_ON);
                spike_off_q[c] <= (next_spike[c] == SPIKE_OFF);
            end
        end else if (ena && bus.out_ready) begin
            // A transfer while ena=0 is not consumed, so the drop is gated by ena.
            out_valid_q <= 1'b0;
        end
    end

endmodule
